// File: rtl/uart_byte_receiver.sv
// Oversampling 8N1 UART receiver with a small output FIFO and single-cycle error pulses.
// Optional even-parity frame support is compiled in with `define UART_RX_PARITY_EN.
module uart_byte_receiver #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_receive,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun_error,
  output logic       parity_error
);

  // state  | meaning
  // IDLE   | line idle, waiting for a low synchronized bit
  // START  | half-bit wait, then confirm the start bit (high = glitch)
  // DATA   | sample 8 data bits, LSB first, one per bit period
  // PARITY | sample the parity bit (parity builds only)
  // STOP   | sample the stop bit, then write, drop or flag the byte
  // BREAK  | line held low after a framing fault, wait for it to go high
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  localparam int CPB = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int TW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TC_FULL = TW'(CPB - 1);
  localparam logic [TW-1:0] TC_HALF = TW'(CPB / 2 - 1);

  logic          rx_meta_q, rx_s_q;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          framing_q, framing_d;
  logic          overrun_q, overrun_d;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          wr_en, pop, fifo_full, fifo_empty, parity_bad, timer_full;

`ifdef UART_RX_PARITY_EN
  logic par_bit_q, par_bit_d;
  logic parity_q, parity_d;
  assign parity_bad   = ^{shift_q, par_bit_q};
  assign parity_error = parity_q;
`else
  assign parity_bad   = 1'b0;
  assign parity_error = 1'b0;
`endif

  assign fifo_empty     = (wr_ptr_q == rd_ptr_q);
  assign fifo_full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_out_valid = !fifo_empty;
  assign data_out       = mem_q[rd_ptr_q[AW-1:0]];
  assign pop            = data_out_valid && data_out_ready;
  assign framing_error  = framing_q;
  assign overrun_error  = overrun_q;
  assign timer_full     = (timer_q == TC_FULL);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    framing_d = 1'b0;
    overrun_d = 1'b0;
    wr_en     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    parity_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (timer_q == TC_HALF) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (timer_full) begin
          timer_d   = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (timer_full) begin
          timer_d   = '0;
          par_bit_d = rx_s_q;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (timer_full) begin
          timer_d = '0;
          if (!rx_s_q) begin
            // A framing fault masks any parity fault on the same frame.
            framing_d = 1'b1;
            state_d   = S_BREAK;
          end else begin
            state_d = S_IDLE;
            if (parity_bad) begin
`ifdef UART_RX_PARITY_EN
              parity_d = 1'b1;
`endif
            end else if (fifo_full && !pop) begin
              overrun_d = 1'b1;
            end else begin
              wr_en = 1'b1;
            end
          end
        end
      end
      S_BREAK: begin
        timer_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      framing_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      parity_q  <= 1'b0;
`endif
    end else begin
      rx_meta_q <= uart_receive;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      framing_q <= framing_d;
      overrun_q <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
      parity_q  <= parity_d;
`endif
    end
  end

  // When full, a simultaneous pop frees the head slot, which is the one being written.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Scoreboard bench for uart_byte_receiver at 10 clocks per bit; parity cases run
// only when UART_RX_PARITY_EN is defined.
module tb_uart_byte_receiver;
  logic       clock = 1'b0;
  logic       reset;
  logic       uart_receive;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error, overrun_error, parity_error;

  int vectors = 0, miscompares = 0;
  int beats = 0, fr_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;
  int b0, f0, o0, p0;

  uart_byte_receiver #(
    .CLOCK_FREQUENCY(100),
    .BAUD_RATE(10),
    .FIFO_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .uart_receive(uart_receive),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .framing_error(framing_error),
    .overrun_error(overrun_error),
    .parity_error(parity_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clock) begin
    if (reset) begin
      if (framing_error) fr_cnt++;
      if (overrun_error) ov_cnt++;
      if (parity_error)  pe_cnt++;
      if (data_out_valid && data_out_ready) begin
        beats++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", data_out);
        end else begin
          mon_exp = exp_q.pop_front();
          if (data_out !== mon_exp) begin
            miscompares++;
            $display("FAIL data_out: got 0x%0h, expected 0x%0h", data_out, mon_exp);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic hold(input logic v, input int n);
    uart_receive = v;
    idle(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par,
                            input int stop_len);
    hold(1'b0, 10);
    for (int i = 0; i < 8; i++) hold(b[i], 10);
`ifdef UART_RX_PARITY_EN
    hold(par, 10);
`else
    if (par === 1'bz) hold(1'b1, 0);
`endif
    hold(stop, stop_len);
    uart_receive = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"}, int'(data_out), 0);
    check({tag, "_valid"}, int'(data_out_valid), 0);
    check({tag, "_framing"}, int'(framing_error), 0);
    check({tag, "_overrun"}, int'(overrun_error), 0);
    check({tag, "_parity"}, int'(parity_error), 0);
  endtask

  initial begin
    reset          = 1'b0;
    uart_receive   = 1'b1;
    data_out_ready = 1'b1;
    idle(3);
    check_reset_outputs("reset");
    reset = 1'b1;
    idle(5);

    // Back-to-back 0x48, 0x00
    b0 = beats; f0 = fr_cnt; o0 = ov_cnt;
    exp_q.push_back(8'h48);
    send_frame(8'h48, 1'b1, ^8'h48, 10);
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, 1'b0, 10);
    idle(15);
    check("b2b_queue_left", exp_q.size(), 0);
    check("b2b_beats", beats - b0, 2);
    check("b2b_framing", fr_cnt - f0, 0);
    check("b2b_overrun", ov_cnt - o0, 0);

    // 3-clock glitch
    b0 = beats; f0 = fr_cnt; o0 = ov_cnt;
    hold(1'b0, 3);
    hold(1'b1, 40);
    check("glitch_beats", beats - b0, 0);
    check("glitch_framing", fr_cnt - f0, 0);
    check("glitch_overrun", ov_cnt - o0, 0);
    check("glitch_valid", int'(data_out_valid), 0);

    // Framing fault with held-low line, then a good frame
    b0 = beats; f0 = fr_cnt;
    send_frame(8'h6C, 1'b0, ^8'h6C, 30);
    hold(1'b1, 20);
    check("frame_err_pulses", fr_cnt - f0, 1);
    check("frame_err_beats", beats - b0, 0);
    exp_q.push_back(8'h6F);
    send_frame(8'h6F, 1'b1, ^8'h6F, 10);
    idle(15);
    check("after_frame_queue_left", exp_q.size(), 0);
    check("after_frame_beats", beats - b0, 1);
    check("after_frame_framing", fr_cnt - f0, 1);

    // Overrun with consumer stalled
    data_out_ready = 1'b0;
    b0 = beats; o0 = ov_cnt;
    exp_q.push_back(8'h48); send_frame(8'h48, 1'b1, ^8'h48, 10);
    exp_q.push_back(8'h65); send_frame(8'h65, 1'b1, ^8'h65, 10);
    exp_q.push_back(8'h6C); send_frame(8'h6C, 1'b1, ^8'h6C, 10);
    exp_q.push_back(8'h6F); send_frame(8'h6F, 1'b1, ^8'h6F, 10);
    check("overrun_before_fifth", ov_cnt - o0, 0);
    send_frame(8'h21, 1'b1, ^8'h21, 10);
    idle(5);
    check("overrun_pulses", ov_cnt - o0, 1);
    check("stall_valid", int'(data_out_valid), 1);
    check("stall_head", int'(data_out), 8'h48);
    idle(3);
    check("stall_head_stable", int'(data_out), 8'h48);
    check("stall_beats", beats - b0, 0);
    data_out_ready = 1'b1;
    idle(10);
    check("drain_queue_left", exp_q.size(), 0);
    check("drain_beats", beats - b0, 4);
    check("drain_valid", int'(data_out_valid), 0);

    // Reset during bit 4 of 0x55
    b0 = beats; f0 = fr_cnt;
    hold(1'b0, 10);
    for (int i = 0; i < 4; i++) hold(i[0] ? 1'b0 : 1'b1, 10);
    hold(1'b1, 5);
    reset = 1'b0;
    idle(2);
    check_reset_outputs("midframe_reset");
    hold(1'b1, 3);
    reset = 1'b1;
    idle(5);
    exp_q.push_back(8'hAA);
    send_frame(8'hAA, 1'b1, ^8'hAA, 10);
    idle(15);
    check("post_reset_queue_left", exp_q.size(), 0);
    check("post_reset_beats", beats - b0, 1);
    check("post_reset_framing", fr_cnt - f0, 0);

`ifdef UART_RX_PARITY_EN
    b0 = beats; p0 = pe_cnt;
    send_frame(8'h03, 1'b1, 1'b1, 10);
    idle(15);
    check("parity_err_pulses", pe_cnt - p0, 1);
    check("parity_err_beats", beats - b0, 0);
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b1, 1'b0, 10);
    idle(15);
    check("parity_ok_queue_left", exp_q.size(), 0);
    check("parity_ok_beats", beats - b0, 1);
    check("parity_ok_pulses", pe_cnt - p0, 1);
`else
    check("parity_never_pulses", pe_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
